i2c_arbiter: RTL and testbench

- Shares the single I2C `master` between `NREQ` requesters with round-robin arbitration.
- Sequences each granted transaction: latches the command, issues a start pulse, watches the master state code, returns read data, and aborts transactions stalled waiting for ACK.
- Sits between the client blocks and the `master` command port; the I2C pins (`sclk`, `sda_in`, `sda_out`) remain on the master.

---
 rtl/i2c_arbiter.sv | 158 +++++++++++++++
 tb/tb_i2c_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C master among NREQ clients: grants one
// requester, latches its command, strobes the master and watches it to completion.
module i2c_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*8-1:0]        req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          err,
  output logic [7:0]               rdata,
  output logic                     m_start,
  output logic                     m_abort,
  output logic                     m_rw,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [7:0]               m_wdata,
  input  logic [2:0]               m_state,
  input  logic [7:0]               m_rdata
);
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCNT_W = $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [2:0] MS_IDLE = 3'd0;
  localparam logic [2:0] MS_WAIT = 3'd2;
  localparam logic [2:0] MS_DONE = 3'd5;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_BUSY, ARB_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d, win_q, win_d;
  logic [IDX_W-1:0]    pick, cand;
  logic                pick_vld;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [7:0]          rdata_q, rdata_d, wdata_q, wdata_d;
  logic                start_q, start_d, abort_q, abort_d, rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    abort_d = 1'b0;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          win_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          rw_d    = req_rw[pick];
          addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(pick)*8 +: 8];
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        start_d = 1'b1;
        state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (m_state == MS_WAIT) begin
          wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
        end
        // DONE is tested first so it wins over a coincident timeout.
        if (m_state == MS_DONE) begin
          if (rw_q) begin
            rdata_d = m_rdata;
          end
          done_d  = NREQ'(1) << win_q;
          state_d = ARB_RELEASE;
        end else if (m_state == MS_WAIT && wcnt_q == WCNT_MAX) begin
          abort_d = 1'b1;
          err_d   = NREQ'(1) << win_q;
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        if (m_state == MS_IDLE) begin
          gnt_d   = '0;
          last_d  = win_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= LAST_RST;
      win_q   <= '0;
      wcnt_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      wcnt_q  <= wcnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      abort_q <= abort_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign m_start = start_q;
  assign m_abort = abort_q;
  assign m_rw    = rw_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter; the bench itself plays the I2C master by
// driving m_state/m_rdata step by step.
module tb_i2c_arbiter;
  localparam int NREQ = 4;
  localparam int ADDR_W = 7;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req, req_rw;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*8-1:0]      req_wdata;
  logic [NREQ-1:0]        gnt, done, err;
  logic [7:0]             rdata, m_wdata, m_rdata;
  logic                   m_start, m_abort, m_rw;
  logic [ADDR_W-1:0]      m_addr;
  logic [2:0]             m_state;

  int checks = 0;
  int failures = 0;
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  i2c_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_start(m_start), .m_abort(m_abort), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_state(m_state), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    m_state = 3'd0;
    m_rdata = 8'h00;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_start", 32'(m_start), 0);
    chk("rst_abort", 32'(m_abort), 0);
    chk("rst_cmd", {m_rw, m_addr, m_wdata}, 0);

    // Round-robin with all four requesting continuously.
    rst = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << exp_order[k]);
      tick();
      chk("rr_start", 32'(m_start), 1);
      m_state = 3'd5;
      tick();
      chk("rr_done", 32'(done), 32'(1) << exp_order[k]);
      m_state = 3'd0;
      tick();
      chk("rr_gap", 32'(gnt), 0);
    end
    req = '0;

    // Single write by requester 1.
    req = 4'b0010;
    req_rw = 4'b0000;
    req_addr[1*ADDR_W +: ADDR_W] = 7'h50;
    req_wdata[1*8 +: 8] = 8'hA5;
    tick();
    chk("wr_gnt", 32'(gnt), 'h2);
    chk("wr_addr", 32'(m_addr), 'h50);
    chk("wr_wdata", 32'(m_wdata), 'hA5);
    chk("wr_rw", 32'(m_rw), 0);
    req = '0;
    req_addr[1*ADDR_W +: ADDR_W] = 7'h01;
    tick();
    chk("wr_start", 32'(m_start), 1);
    m_state = 3'd1;
    tick();
    chk("wr_start_end", 32'(m_start), 0);
    chk("wr_addr_hold", 32'(m_addr), 'h50);
    chk("wr_gnt_hold", 32'(gnt), 'h2);
    m_state = 3'd4;
    tick();
    m_state = 3'd5;
    tick();
    chk("wr_done", 32'(done), 'h2);
    chk("wr_err", 32'(err), 0);
    m_state = 3'd0;
    tick();
    chk("wr_done_end", 32'(done), 0);
    chk("wr_release", 32'(gnt), 0);

    // Read by requester 0, then a write by requester 2 must not disturb rdata.
    req = 4'b0001;
    req_rw = 4'b0001;
    req_addr[0 +: ADDR_W] = 7'h3C;
    tick();
    chk("rd_gnt", 32'(gnt), 'h1);
    chk("rd_addr", 32'(m_addr), 'h3C);
    chk("rd_rw", 32'(m_rw), 1);
    req = '0;
    tick();
    m_state = 3'd3;
    tick();
    m_state = 3'd5;
    m_rdata = 8'hF6;
    tick();
    chk("rd_done", 32'(done), 'h1);
    chk("rd_rdata", 32'(rdata), 'hF6);
    m_state = 3'd0;
    m_rdata = 8'h00;
    tick();
    chk("rd_release", 32'(gnt), 0);
    req = 4'b0100;
    req_rw = 4'b0000;
    req_addr[2*ADDR_W +: ADDR_W] = 7'h11;
    req_wdata[2*8 +: 8] = 8'h22;
    tick();
    chk("wr2_gnt", 32'(gnt), 'h4);
    req = '0;
    tick();
    m_state = 3'd4;
    tick();
    m_state = 3'd5;
    m_rdata = 8'h99;
    tick();
    chk("wr2_done", 32'(done), 'h4);
    chk("wr2_rdata_hold", 32'(rdata), 'hF6);
    m_state = 3'd0;
    m_rdata = 8'h00;
    tick();
    chk("wr2_release", 32'(gnt), 0);

    // NACK timeout: master sits in WAITING.
    req = 4'b1000;
    tick();
    chk("to_gnt", 32'(gnt), 'h8);
    req = '0;
    tick();
    m_state = 3'd1;
    tick();
    m_state = 3'd2;
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      tick();
      chk("to_early", {m_abort, err}, 0);
    end
    tick();
    chk("to_abort", 32'(m_abort), 1);
    chk("to_err", 32'(err), 'h8);
    chk("to_nodone", 32'(done), 0);
    tick();
    chk("to_pulse_end", {m_abort, err}, 0);
    chk("to_gnt_hold", 32'(gnt), 'h8);
    m_state = 3'd0;
    tick();
    chk("to_release", 32'(gnt), 0);

    // DONE arrives exactly when the wait counter is at TIMEOUT-1.
    req = 4'b0001;
    req_rw = 4'b0000;
    tick();
    chk("sim_gnt", 32'(gnt), 'h1);
    req = '0;
    tick();
    m_state = 3'd2;
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      tick();
    end
    m_state = 3'd5;
    tick();
    chk("sim_done", 32'(done), 'h1);
    chk("sim_err", 32'(err), 0);
    chk("sim_abort", 32'(m_abort), 0);
    m_state = 3'd0;
    tick();
    chk("sim_release", 32'(gnt), 0);

    // Reset asserted while the master is busy.
    req = 4'b0010;
    req_addr[1*ADDR_W +: ADDR_W] = 7'h2A;
    req_wdata[1*8 +: 8] = 8'h5A;
    req_rw = 4'b0010;
    tick();
    chk("mr_gnt", 32'(gnt), 'h2);
    req = '0;
    tick();
    m_state = 3'd2;
    tick();
    tick();
    rst = 1'b0;
    m_state = 3'd0;
    #1;
    chk("mr_gnt_clr", 32'(gnt), 0);
    chk("mr_cmd_clr", {m_rw, m_addr, m_wdata}, 0);
    chk("mr_rdata_clr", 32'(rdata), 0);
    chk("mr_strobes_clr", {m_start, m_abort, done, err}, 0);
    tick();
    chk("mr_no_pulse", {done, err}, 0);
    rst = 1'b1;
    req = 4'b0100;
    req_rw = 4'b0000;
    tick();
    chk("mr_first_gnt", 32'(gnt), 'h4);
    req = '0;
    tick();
    chk("mr_start", 32'(m_start), 1);
    m_state = 3'd5;
    tick();
    chk("mr_done", 32'(done), 'h4);
    m_state = 3'd0;
    tick();
    chk("mr_release", 32'(gnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
